y86_fetch_seq: RTL and testbench



---
 rtl/y86_fetch_seq.sv | 187 ++++++++++++++++++
 tb/tb_y86_fetch_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/y86_fetch_seq.sv
// Multi-cycle Y86-64 instruction fetch: reads the instruction at PC one byte per
// accepted request, decodes its length and fields, and strobes done with valP.
module y86_fetch_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] PC,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_valid,
    input  logic        mem_err,
    output logic        done,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_error
);

    localparam int unsigned AW = 64;
    localparam int unsigned LW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYTE0,
        S_REGS,
        S_CONST,
        S_DONE
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   pc_q;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   valc_q;
    logic [AW-1:0]   valp_q;
    logic [3:0]      icode_q;
    logic [3:0]      ifun_q;
    logic [3:0]      ra_q;
    logic [3:0]      rb_q;
    logic [2:0]      cnt_q;
    logic            req_q;
    logic            done_q;
    logic            ivalid_q;
    logic            ierr_q;

    logic            accept_c;
    logic [3:0]      b0_code_c;
    logic [LW-1:0]   b0_len_c;

    // Instruction length in bytes from icode; unknown codes consume one byte.
    function automatic logic [LW-1:0] instr_len(input logic [3:0] c);
        case (c)
            4'h0, 4'h1, 4'h9:             return LW'(1);
            4'h2, 4'h6, 4'hA, 4'hB:       return LW'(2);
            4'h7, 4'h8:                   return LW'(9);
            4'h3, 4'h4, 4'h5:             return LW'(10);
            default:                      return LW'(1);
        endcase
    endfunction

    function automatic logic has_regs(input logic [3:0] c);
        return (instr_len(c) == LW'(2)) || (instr_len(c) == LW'(10));
    endfunction

    function automatic logic has_const(input logic [3:0] c);
        return instr_len(c) >= LW'(9);
    endfunction

    assign accept_c  = req_q && mem_valid;
    assign b0_code_c = mem_rdata[7:4];
    assign b0_len_c  = instr_len(b0_code_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            addr_q   <= '0;
            valc_q   <= '0;
            valp_q   <= '0;
            icode_q  <= 4'h0;
            ifun_q   <= 4'h0;
            ra_q     <= 4'hF;
            rb_q     <= 4'hF;
            cnt_q    <= 3'd0;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            ivalid_q <= 1'b1;
            ierr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept_c) begin
                addr_q <= addr_q + AW'(1);
            end
            // Any erroring accept aborts the remaining bytes.
            if (accept_c && mem_err) begin
                ierr_q  <= 1'b1;
                req_q   <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
                if (state_q == S_BYTE0) begin
                    valp_q <= pc_q + AW'(1);
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            pc_q    <= PC;
                            addr_q  <= PC;
                            ra_q    <= 4'hF;
                            rb_q    <= 4'hF;
                            valc_q  <= '0;
                            ierr_q  <= 1'b0;
                            req_q   <= 1'b1;
                            state_q <= S_BYTE0;
                        end
                    end
                    S_BYTE0: begin
                        if (accept_c) begin
                            icode_q  <= b0_code_c;
                            ifun_q   <= mem_rdata[3:0];
                            ivalid_q <= (b0_code_c <= 4'hB);
                            valp_q   <= pc_q + AW'(b0_len_c);
                            cnt_q    <= 3'd0;
                            if (has_regs(b0_code_c)) begin
                                state_q <= S_REGS;
                            end else if (has_const(b0_code_c)) begin
                                state_q <= S_CONST;
                            end else begin
                                req_q   <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end
                    end
                    S_REGS: begin
                        if (accept_c) begin
                            ra_q <= mem_rdata[7:4];
                            rb_q <= mem_rdata[3:0];
                            if (has_const(icode_q)) begin
                                state_q <= S_CONST;
                            end else begin
                                req_q   <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end
                    end
                    S_CONST: begin
                        if (accept_c) begin
                            valc_q[{cnt_q, 3'b000} +: 8] <= mem_rdata;
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                req_q   <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign done        = done_q;
    assign icode       = icode_q;
    assign ifun        = ifun_q;
    assign rA          = ra_q;
    assign rB          = rb_q;
    assign valC        = valc_q;
    assign valP        = valp_q;
    assign instr_valid = ivalid_q;
    assign imem_error  = ierr_q;

endmodule

// File: tb/tb_y86_fetch_seq.sv
// Bench for y86_fetch_seq: directed and randomized fetches against a byte-level
// reference model of the Y86-64 instruction encoding.
module tb_y86_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] PC;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_valid;
    logic        mem_err;
    logic        done;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_valid;
    logic        imem_error;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [logic [63:0]];
    logic [7:0] bq [$];

    y86_fetch_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .PC(PC),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .mem_err(mem_err), .done(done),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .instr_valid(instr_valid), .imem_error(imem_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    task automatic load(input logic [63:0] pc, input logic [7:0] b [$]);
        mem.delete();
        foreach (b[i]) mem[pc + 64'(i)] = b[i];
    endtask

    function automatic int ref_len(input logic [3:0] c);
        case (c)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 1;
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req"},   64'(mem_req), 64'd0);
        check_eq({tag, "_addr"},  mem_addr, 64'd0);
        check_eq({tag, "_done"},  64'(done), 64'd0);
        check_eq({tag, "_icode"}, 64'({icode, ifun}), 64'h00);
        check_eq({tag, "_regs"},  64'({rA, rB}), 64'hFF);
        check_eq({tag, "_valC"},  valC, 64'd0);
        check_eq({tag, "_valP"},  valP, 64'd0);
        check_eq({tag, "_flags"}, 64'({instr_valid, imem_error}), 64'b10);
    endtask

    // Fetch one instruction from mem at pc. stall = idle cycles before each byte,
    // err_idx = byte index that reports mem_err (-1: none), noise = toggle start/PC.
    task automatic run_fetch(input string tag, input logic [63:0] pc, input int stall,
                             input int err_idx, input bit noise);
        logic [7:0]  b0, b1;
        int          len, fetched, coff, cyc, accepts, waitc, exp_done;
        bit          hasreg, got_done;
        logic [63:0] exp_valc;
        logic [3:0]  exp_ra, exp_rb;

        b0       = mem_rd(pc);
        b1       = mem_rd(pc + 64'd1);
        len      = ref_len(b0[7:4]);
        hasreg   = (len == 2) || (len == 10);
        coff     = hasreg ? 2 : 1;
        fetched  = (err_idx >= 0) ? err_idx + 1 : len;
        exp_ra   = (hasreg && fetched >= 2 && err_idx != 1) ? b1[7:4] : 4'hF;
        exp_rb   = (hasreg && fetched >= 2 && err_idx != 1) ? b1[3:0] : 4'hF;
        exp_valc = '0;
        if (len >= 9) begin
            for (int k = 0; k < 8; k++) begin
                if (coff + k < fetched && coff + k != err_idx)
                    exp_valc[8*k +: 8] = mem_rd(pc + 64'(coff + k));
            end
        end
        exp_done = fetched * (stall + 1) + 1;

        @(negedge clk);
        check_eq({tag, "_idle_done"}, 64'(done), 64'd0);
        check_eq({tag, "_idle_req"},  64'(mem_req), 64'd0);
        start     = 1'b1;
        PC        = pc;
        mem_valid = 1'b0;
        mem_err   = 1'b0;
        cyc = 0; accepts = 0; waitc = 0; got_done = 1'b0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            mem_valid = 1'b0;
            mem_err   = 1'b0;
            mem_rdata = 8'($urandom);
            if (done) begin
                start    = 1'b0;
                got_done = 1'b1;
                break;
            end
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) PC = {$urandom, $urandom};
            if (mem_req) begin
                check_eq({tag, "_addr"}, mem_addr, pc + 64'(accepts));
                if (waitc < stall) begin
                    waitc++;
                end else begin
                    mem_valid = 1'b1;
                    mem_rdata = mem_rd(mem_addr);
                    mem_err   = (accepts == err_idx);
                    accepts++;
                    waitc = 0;
                end
            end
        end
        if (!got_done) begin
            check_eq({tag, "_done_timeout"}, 64'd0, 64'd1);
        end else begin
            check_eq({tag, "_done_cyc"}, 64'(cyc), 64'(exp_done));
            check_eq({tag, "_accepts"},  64'(accepts), 64'(fetched));
            if (err_idx != 0)
                check_eq({tag, "_icode"}, 64'({icode, ifun}), 64'(b0));
            check_eq({tag, "_regs"},  64'({rA, rB}), 64'({exp_ra, exp_rb}));
            check_eq({tag, "_valC"},  valC, exp_valc);
            check_eq({tag, "_valP"},  valP, (err_idx == 0) ? pc + 64'd1 : pc + 64'(len));
            check_eq({tag, "_ivalid"}, 64'(instr_valid), 64'(b0[7:4] <= 4'hB));
            check_eq({tag, "_ierr"},  64'(imem_error), 64'(err_idx >= 0));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; PC = '0;
        mem_rdata = '0; mem_valid = 1'b0; mem_err = 1'b0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        bq = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        load(64'h100, bq);
        run_fetch("irmovq", 64'h100, 0, -1, 1'b0);
        check_eq("irmovq_valC_abs", valC, 64'h0123456789ABCDEF);
        check_eq("irmovq_valP_abs", valP, 64'h10A);

        bq = '{8'h73, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load(64'h40, bq);
        run_fetch("jxx", 64'h40, 0, -1, 1'b0);
        check_eq("jxx_valC_abs", valC, 64'h200);

        bq = '{8'h90};
        load(64'hFFFF_FFFF_FFFF_FFFF, bq);
        run_fetch("ret_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 0, -1, 1'b0);
        check_eq("ret_valP_abs", valP, 64'd0);
        bq = '{8'h60, 8'h23};
        load(64'h10, bq);
        run_fetch("opq", 64'h10, 0, -1, 1'b0);
        check_eq("opq_valP_abs", valP, 64'h12);

        bq = '{8'hC0};
        load(64'h3000, bq);
        run_fetch("invalid", 64'h3000, 0, -1, 1'b0);

        bq = '{8'h40, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        load(64'h500, bq);
        run_fetch("rmmov_err", 64'h500, 0, 3, 1'b0);

        bq = '{8'h50, 8'h45, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22};
        load(64'h800, bq);
        run_fetch("mrmov_stall", 64'h800, 2, -1, 1'b1);

        // Reset during CONST: after byte0, regs and two constant bytes.
        bq = '{8'h40, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        load(64'h200, bq);
        @(negedge clk);
        start = 1'b1; PC = 64'h200;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1;
            mem_rdata = mem_rd(mem_addr);
            @(negedge clk);
        end
        mem_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("midreset_no_done", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        run_fetch("after_reset", 64'h200, 0, -1, 1'b0);

        for (int t = 0; t < 25; t++) begin
            logic [63:0] rpc;
            logic [7:0]  b0;
            int          l, e;
            rpc = {$urandom, $urandom};
            if (t % 5 == 0) rpc = 64'hFFFF_FFFF_FFFF_FFFA;
            b0 = 8'($urandom);
            bq = '{b0};
            for (int i = 1; i < 10; i++) bq.push_back(8'($urandom));
            load(rpc, bq);
            l = ref_len(b0[7:4]);
            e = (l > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, l - 1)) : -1;
            run_fetch("rand", rpc, int'($urandom_range(0, 2)), e, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        check_eq("final_done_low", 64'(done), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
